uart_tx_param: RTL and testbench

Parametrised UART serial transmitter, the successor to the fixed 8-bit frame transmitter.
- Configurable data width, parity mode, stop-bit count and bit period (clock cycles per bit).
- Accepts words over a valid/ready handshake and drives one serial line, LSB first.
- Sits between the host-side data source and the serial link, one instance per channel.

---
 rtl/uart_tx_param.sv | 213 +++++++++++++++++++++
 tb/tb_uart_tx_param.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_W data bits LSB first, optional parity, STOP_BITS stop bits.
// Define UART_TX_FIFO_EN to add a FIFO_DEPTH-entry input FIFO with back-to-back frames.
module uart_tx_param #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 1,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_W-1:0]                tx_data,
  input  logic                             tx_valid,
  output logic                             tx_ready,
  output logic                             serial_out,
  output logic                             busy,
  output logic                             tx_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level
);

  localparam int LVL_W  = $clog2(FIFO_DEPTH + 1);
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W  = 4;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  DATA_LAST = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0]  STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam logic              PAR_INV   = (PARITY == 2);

  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
    $error("uart_tx_param: DATA_W must be in 5..9");
  end
  if (CLKS_PER_BIT < 1) begin : g_bad_clks_per_bit
    $error("uart_tx_param: CLKS_PER_BIT must be >= 1");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t              state_reg, state_next;
  logic [BAUD_W-1:0]   baud_reg, baud_next;
  logic [IDX_W-1:0]    bit_idx_reg, bit_idx_next;
  logic [DATA_W-1:0]   shift_reg, shift_next;
  logic                parity_reg, parity_next;
  logic                serial_reg, serial_next;
  logic                done_reg, done_next;

  logic                bit_end;
  logic                frame_end;
  logic                load;
  logic [DATA_W-1:0]   load_data;
  logic [DATA_W:0]     xor_chain;

  assign bit_end   = (baud_reg == BAUD_LAST);
  assign frame_end = (state_reg == S_STOP) && bit_end && (bit_idx_reg == STOP_LAST);

  assign xor_chain[0] = 1'b0;
  genvar gi;
  for (gi = 0; gi < DATA_W; gi++) begin : g_parity
    assign xor_chain[gi+1] = xor_chain[gi] ^ load_data[gi];
  end

`ifdef UART_TX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("uart_tx_param: FIFO_DEPTH must be a power of two >= 2");
  end

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [LVL_W-1:0]  count_reg;
  logic              fifo_full, fifo_empty, push, pop;

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == LVL_W'(FIFO_DEPTH));
  // Next frame starts on the edge that ends the previous stop bit, so no idle gap.
  assign load       = !fifo_empty && ((state_reg == S_IDLE) || frame_end);
  assign pop        = load;
  assign tx_ready   = !fifo_full || pop;
  assign push       = tx_valid && tx_ready;
  assign load_data  = fifo_mem[rd_ptr_reg];
  assign fifo_level = count_reg;
  assign busy       = (state_reg != S_IDLE) || !fifo_empty;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end
`else
  logic ready_reg;
  logic busy_reg;

  assign load       = (state_reg == S_IDLE) && tx_valid && ready_reg;
  assign load_data  = tx_data;
  assign tx_ready   = ready_reg;
  assign busy       = busy_reg;
  assign fifo_level = '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ready_reg <= 1'b1;
      busy_reg  <= 1'b0;
    end else begin
      ready_reg <= (state_next == S_IDLE);
      busy_reg  <= (state_next != S_IDLE);
    end
  end
`endif

  // State register and frame datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= S_IDLE;
      baud_reg    <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      parity_reg  <= 1'b0;
      serial_reg  <= 1'b1;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      baud_reg    <= baud_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
      parity_reg  <= parity_next;
      serial_reg  <= serial_next;
      done_reg    <= done_next;
    end
  end

  // Next-state logic: FSM transitions, baud/bit counters, shifter and parity capture.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (load) state_next = S_START;
      S_START:  if (bit_end) state_next = S_DATA;
      S_DATA:   if (bit_end && (bit_idx_reg == DATA_LAST)) begin
                  state_next = (PARITY != 0) ? S_PARITY : S_STOP;
                end
      S_PARITY: if (bit_end) state_next = S_STOP;
      S_STOP:   if (frame_end) state_next = load ? S_START : S_IDLE;
      default:  state_next = S_IDLE;
    endcase

    baud_next = ((state_reg == S_IDLE) || bit_end) ? '0 : baud_reg + 1'b1;

    bit_idx_next = bit_idx_reg;
    if (bit_end) begin
      if (state_next != state_reg) begin
        bit_idx_next = '0;
      end else if ((state_reg == S_DATA) || (state_reg == S_STOP)) begin
        bit_idx_next = bit_idx_reg + 1'b1;
      end
    end

    shift_next = shift_reg;
    if (load) begin
      shift_next = load_data;
    end else if ((state_reg == S_DATA) && bit_end) begin
      shift_next = shift_reg >> 1;
    end

    parity_next = load ? (xor_chain[DATA_W] ^ PAR_INV) : parity_reg;
  end

  // Output logic: serial level follows the state being entered, so the line is registered.
  always_comb begin
    serial_next = 1'b1;
    done_next   = frame_end;
    case (state_next)
      S_START:  serial_next = 1'b0;
      S_DATA:   serial_next = shift_next[0];
      S_PARITY: serial_next = parity_reg;
      default:  serial_next = 1'b1;
    endcase
  end

  assign serial_out = serial_reg;
  assign tx_done    = done_reg;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: three configurations checked against a frame-level bit model.
module tb_uart_tx_param;

  localparam int DW  [3] = '{8, 8, 7};
  localparam int CPB [3] = '{4, 4, 1};
  localparam int PAR [3] = '{1, 2, 0};
  localparam int STB [3] = '{1, 1, 2};
`ifdef UART_TX_FIFO_EN
  localparam logic FIFO_MODE = 1'b1;
`else
  localparam logic FIFO_MODE = 1'b0;
`endif

  logic       clk;
  logic       rst_a, rst_b, rst_c;
  logic       valid_a, valid_b, valid_c;
  logic [7:0] data_a, data_b;
  logic [6:0] data_c;
  logic       ready_a, ready_b, ready_c;
  logic       serial_a, serial_b, serial_c;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;
  logic [2:0] level_a, level_b, level_c;

  int vectors = 0;
  int miscompares = 0;

  uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst_a), .tx_data(data_a), .tx_valid(valid_a), .tx_ready(ready_a),
    .serial_out(serial_a), .busy(busy_a), .tx_done(done_a), .fifo_level(level_a));
  uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst_b), .tx_data(data_b), .tx_valid(valid_b), .tx_ready(ready_b),
    .serial_out(serial_b), .busy(busy_b), .tx_done(done_b), .fifo_level(level_b));
  uart_tx_param #(.DATA_W(7), .CLKS_PER_BIT(1), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_c (
    .clk(clk), .rst(rst_c), .tx_data(data_c), .tx_valid(valid_c), .tx_ready(ready_c),
    .serial_out(serial_c), .busy(busy_c), .tx_done(done_c), .fifo_level(level_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic v, input logic [8:0] d);
    case (sel)
      0:       begin valid_a = v; data_a = d[7:0]; end
      1:       begin valid_b = v; data_b = d[7:0]; end
      default: begin valid_c = v; data_c = d[6:0]; end
    endcase
  endtask

  // Observation vector: {fifo_level, serial_out, tx_done, tx_ready, busy}
  function automatic logic [6:0] obs(input int sel);
    case (sel)
      0:       return {level_a, serial_a, done_a, ready_a, busy_a};
      1:       return {level_b, serial_b, done_b, ready_b, busy_b};
      default: return {level_c, serial_c, done_c, ready_c, busy_c};
    endcase
  endfunction

  function automatic int nbits(input int sel);
    return 1 + DW[sel] + ((PAR[sel] != 0) ? 1 : 0) + STB[sel];
  endfunction

  // Line level for each bit slot of a frame, in transmission order.
  function automatic logic [15:0] model_frame(input int sel, input logic [8:0] word);
    logic [15:0] f;
    int n;
    int ones;
    f = '1;
    f[0] = 1'b0;
    n = 1;
    ones = 0;
    for (int i = 0; i < DW[sel]; i++) begin
      f[n] = word[i];
      ones += int'(word[i]);
      n++;
    end
    if (PAR[sel] == 1) f[n] = (ones % 2 == 1);
    else if (PAR[sel] == 2) f[n] = (ones % 2 == 0);
    return f;
  endfunction

  task automatic run_frame(input int sel, input logic [8:0] word, input int gap,
                           input string name, output logic [15:0] cap);
    int cpb;
    int fl;
    int cnt;
    logic [15:0] bits;
    logic [6:0] exp_v, got_v;
    cpb = CPB[sel];
    fl = nbits(sel) * cpb;
    bits = model_frame(sel, word);
    cap = '1;
    drive(sel, 1'b0, 9'($urandom));
    repeat (gap) tick();
    cnt = 0;
    got_v = obs(sel);
    while (got_v[1] !== 1'b1 && cnt < 200) begin
      tick();
      cnt++;
      got_v = obs(sel);
    end
    vectors++;
    if (got_v[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL %s ready_wait got=%b exp=1", name, got_v[1]);
    end
    drive(sel, 1'b1, word);
    tick();
`ifdef UART_TX_FIFO_EN
    drive(sel, 1'b0, 9'($urandom));
    got_v = obs(sel);
    exp_v = {3'd1, 1'b1, 1'b0, 1'b1, 1'b1};
    vectors++;
    if (got_v !== exp_v) begin
      miscompares++;
      $display("FAIL %s push_edge got=%b exp=%b", name, got_v, exp_v);
    end
    tick();
`endif
    drive(sel, 1'b0, 9'($urandom));
    for (int t = 0; t <= fl; t++) begin
      if (t < fl) exp_v = {3'd0, bits[t / cpb], 1'b0, FIFO_MODE, 1'b1};
      else        exp_v = {3'd0, 1'b1, 1'b1, 1'b1, 1'b0};
      got_v = obs(sel);
      if (t < fl && t % cpb == 0) cap[t / cpb] = got_v[3];
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL %s dut%0d word=%h t=%0d got=%b exp=%b", name, sel, word, t, got_v, exp_v);
      end
      if (t < fl) tick();
    end
    $display("frame %s dut%0d word=%h cycles=%0d", name, sel, word, fl);
  endtask

  task automatic test_reset();
    logic [6:0] idle_v, got_v;
    idle_v = 7'b000_1_0_1_0;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    for (int s = 0; s < 3; s++) drive(s, 1'b1, 9'($urandom));
    repeat (3) begin
      tick();
      for (int s = 0; s < 3; s++) begin
        got_v = obs(s);
        vectors++;
        if (got_v !== idle_v) begin
          miscompares++;
          $display("FAIL reset_state dut%0d got=%b exp=%b", s, got_v, idle_v);
        end
      end
    end
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    for (int s = 0; s < 3; s++) drive(s, 1'b0, 9'd0);
    tick();
    for (int s = 0; s < 3; s++) begin
      got_v = obs(s);
      vectors++;
      if (got_v !== idle_v) begin
        miscompares++;
        $display("FAIL reset_release dut%0d got=%b exp=%b", s, got_v, idle_v);
      end
    end
    $display("reset applied and released on all instances");
  endtask

  task automatic test_spec_vectors();
    logic [15:0] cap;
    logic [10:0] exp11;
    logic [9:0] exp10;
    run_frame(0, 9'h0A5, 0, "a5_even", cap);
    exp11 = 11'b10101001010;
    vectors++;
    if (cap[10:0] !== exp11) begin
      miscompares++;
      $display("FAIL a5_even_bits got=%b exp=%b", cap[10:0], exp11);
    end
    run_frame(0, 9'h007, 1, "07_even", cap);
    exp11 = 11'b11000001110;
    vectors++;
    if (cap[10:0] !== exp11) begin
      miscompares++;
      $display("FAIL 07_even_bits got=%b exp=%b", cap[10:0], exp11);
    end
    run_frame(1, 9'h007, 0, "07_odd", cap);
    exp11 = 11'b10000001110;
    vectors++;
    if (cap[10:0] !== exp11) begin
      miscompares++;
      $display("FAIL 07_odd_bits got=%b exp=%b", cap[10:0], exp11);
    end
    run_frame(2, 9'h07F, 0, "7f_w7_2stop", cap);
    exp10 = 10'b1111111110;
    vectors++;
    if (cap[9:0] !== exp10) begin
      miscompares++;
      $display("FAIL 7f_w7_bits got=%b exp=%b", cap[9:0], exp10);
    end
  endtask

  task automatic test_mid_reset();
    logic [15:0] cap;
    logic [10:0] exp11;
    logic [6:0] idle_v, got_v;
    idle_v = 7'b000_1_0_1_0;
    drive(0, 1'b0, 9'd0);
    tick();
    tick();
    drive(0, 1'b1, 9'h0A5);
    tick();
`ifdef UART_TX_FIFO_EN
    drive(0, 1'b0, 9'd0);
    tick();
`endif
    drive(0, 1'b0, 9'd0);
    repeat (11) tick();
    got_v = obs(0);
    vectors++;
    if (got_v[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset_busy_before got=%b exp=1", got_v[0]);
    end
    rst_a = 1'b0;
    drive(0, 1'b1, 9'h03C);
    tick();
    got_v = obs(0);
    vectors++;
    if (got_v !== idle_v) begin
      miscompares++;
      $display("FAIL mid_reset_abort got=%b exp=%b", got_v, idle_v);
    end
    rst_a = 1'b1;
    drive(0, 1'b0, 9'd0);
    for (int i = 0; i < 60; i++) begin
      tick();
      got_v = obs(0);
      vectors++;
      if (got_v !== idle_v) begin
        miscompares++;
        $display("FAIL mid_reset_quiet i=%0d got=%b exp=%b", i, got_v, idle_v);
      end
    end
    $display("mid-frame reset at cycle 12 of a5 frame");
    run_frame(0, 9'h0A5, 0, "after_reset", cap);
    exp11 = 11'b10101001010;
    vectors++;
    if (cap[10:0] !== exp11) begin
      miscompares++;
      $display("FAIL after_reset_bits got=%b exp=%b", cap[10:0], exp11);
    end
  endtask

  task automatic test_random();
    logic [15:0] cap;
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 8; i++) begin
        run_frame(s, 9'($urandom), int'($urandom_range(0, 3)), "random", cap);
      end
    end
  endtask

`ifndef UART_TX_FIFO_EN
  task automatic test_handshake();
    int cpb, fl, p, off, k;
    logic [8:0] word_at [0:199];
    logic [15:0] bits;
    logic [6:0] exp_v, got_v;
    cpb = CPB[0];
    fl = nbits(0) * cpb;
    p = fl + 1;
    drive(0, 1'b0, 9'd0);
    tick();
    tick();
    for (int n = 0; n < 3 * p + 3; n++) begin
      word_at[n] = 9'($urandom_range(0, 255));
      drive(0, 1'b1, word_at[n]);
      tick();
      off = n % p;
      k = n / p;
      bits = model_frame(0, word_at[k * p]);
      if (off < fl) exp_v = {3'd0, bits[off / cpb], 1'b0, 1'b0, 1'b1};
      else          exp_v = {3'd0, 1'b1, 1'b1, 1'b1, 1'b0};
      got_v = obs(0);
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL handshake n=%0d got=%b exp=%b", n, got_v, exp_v);
      end
      if (off == 0) $display("handshake accept edge=%0d word=%h", n, word_at[n]);
    end
    drive(0, 1'b0, 9'd0);
    repeat (fl + 2) tick();
  endtask
`else
  task automatic test_fifo_burst();
    int cpb, fl, last_edge, pushes, pops, lvl, off, k;
    logic pop_next, ser, done, rdy, bsy;
    logic [15:0] bits;
    logic [6:0] exp_v, got_v;
    cpb = CPB[0];
    fl = nbits(0) * cpb;
    last_edge = 1 + 5 * fl;
    drive(0, 1'b0, 9'd0);
    tick();
    tick();
    for (int n = 0; n <= last_edge + 1; n++) begin
      if (n < 5) drive(0, 1'b1, 9'(n + 1));
      else       drive(0, 1'b0, 9'($urandom));
      tick();
      pushes = (n < 5) ? n + 1 : 5;
      pops = 0;
      for (int j = 0; j < 5; j++) if (n >= 1 + j * fl) pops++;
      lvl = pushes - pops;
      pop_next = 1'b0;
      for (int j = 1; j < 5; j++) if (n == j * fl) pop_next = 1'b1;
      if (n >= 1 && n < last_edge) begin
        k = (n - 1) / fl;
        off = (n - 1) % fl;
        bits = model_frame(0, 9'(k + 1));
        ser = bits[off / cpb];
      end else begin
        ser = 1'b1;
      end
      done = (n > 1) && (n <= last_edge) && ((n - 1) % fl == 0);
      bsy = (n < last_edge);
      rdy = (lvl < 4) || pop_next;
      exp_v = {3'(lvl), ser, done, rdy, bsy};
      got_v = obs(0);
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL fifo_burst n=%0d got=%b exp=%b", n, got_v, exp_v);
      end
      if (done) $display("fifo frame done edge=%0d", n);
    end
  endtask
`endif

  initial begin
    valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
    data_a = '0; data_b = '0; data_c = '0;
    test_reset();
    test_spec_vectors();
    test_mid_reset();
    test_random();
`ifdef UART_TX_FIFO_EN
    test_fifo_burst();
`else
    test_handshake();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
